// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 5-8 data bits LSB first, optional parity, 1/1.5/2 stop bits.
// Every bit period is counted in br ticks; tx and din_ready are registered.
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [1:0]        wls,
  input  logic              stb,
  input  logic              pen,
  input  logic              eps,
  output logic              tx,
  output logic              busy
);

  localparam int TW = $clog2(2 * OVERSAMPLE + 1);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_n;
  logic [TW-1:0]     tick_q, tick_n, tick_inc;
  logic [BW-1:0]     bit_q, bit_n;
  logic [DATA_W-1:0] shift_q, shift_n, din_mask, din_masked;
  logic [1:0]        wls_q, wls_n;
  logic              stb_q, stb_n, pen_q, pen_n, par_q, par_n;
  logic              tx_q, tx_n, rdy_q, rdy_n;
  logic              accept, bit_end, last_data;
  int                bit_len;

  always_comb begin
    din_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      din_mask[i] = (i < 5 + int'(wls));
    end
    din_masked = din & din_mask;
    accept     = din_valid & rdy_q;
    tick_inc   = tick_q + TW'(1);

    bit_len = OVERSAMPLE;
    if (state_q == STOP && stb_q) begin
      bit_len = (wls_q == 2'b00) ? (OVERSAMPLE * 3) / 2 : 2 * OVERSAMPLE;
    end
    bit_end   = br && (int'(tick_inc) == bit_len);
    last_data = (int'(bit_q) == 4 + int'(wls_q));

    state_n = state_q;
    tick_n  = tick_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    wls_n   = wls_q;
    stb_n   = stb_q;
    pen_n   = pen_q;
    par_n   = par_q;
    tx_n    = tx_q;

    if (state_q != IDLE && br) begin
      tick_n = bit_end ? '0 : tick_inc;
    end

    case (state_q)
      IDLE: begin
        tx_n   = 1'b1;
        tick_n = '0;
        if (accept) begin
          state_n = START;
          tx_n    = 1'b0;
          bit_n   = '0;
          shift_n = din_masked;
          wls_n   = wls;
          stb_n   = stb;
          pen_n   = pen;
          // Parity is resolved at accept so eps need not be kept for the frame.
          par_n   = eps ? ^din_masked : ~^din_masked;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          tx_n    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift_q >> 1;
          if (last_data) begin
            state_n = pen_q ? PARITY : STOP;
            tx_n    = pen_q ? par_q : 1'b1;
          end else begin
            bit_n = bit_q + BW'(1);
            tx_n  = shift_n[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          tx_n    = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase

    rdy_n = (state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wls_q   <= '0;
      stb_q   <= 1'b0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_n;
      tick_q  <= tick_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      wls_q   <= wls_n;
      stb_q   <= stb_n;
      pen_q   <= pen_n;
      par_q   <= par_n;
      tx_q    <= tx_n;
      rdy_q   <= rdy_n;
    end
  end

  assign tx        = tx_q;
  assign din_ready = rdy_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboarded bench: each accepted character pushes its expected per-br-tick tx levels;
// a monitor consumes them as the DUT transmits.
module tb_uart_tx_serializer;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst, br, din_valid, stb, pen, eps;
  logic [7:0] din;
  logic [1:0] wls;
  logic       din_ready, tx, busy;

  int errors = 0;
  int checks = 0;

  bit exp_lvl[$];
  int exp_len[$];

  int br_period = 4;
  int br_cnt = 0;
  bit br_rand = 1'b0;

  bit in_frame = 1'b0;
  bit chk_end = 1'b0;
  bit frame_bad = 1'b0;
  bit cur[$];
  int idx = 0;
  int len = 0;
  int frames_done = 0;

  uart_tx_serializer #(.OVERSAMPLE(OS), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .br(br), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .wls(wls), .stb(stb), .pen(pen), .eps(eps),
    .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic abort_run(input string nm);
    errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Reference frame as a list of tx levels, one entry per br tick.
  task automatic push_frame(input logic [7:0] d, input logic [1:0] w,
                            input logic s, input logic p, input logic e);
    int wl = 5 + int'(w);
    int total = 0;
    int stop_ticks;
    bit par = 1'b0;
    repeat (OS) begin exp_lvl.push_back(1'b0); total++; end
    for (int i = 0; i < wl; i++) begin
      par ^= d[i];
      repeat (OS) begin exp_lvl.push_back(d[i]); total++; end
    end
    if (p) begin
      repeat (OS) begin exp_lvl.push_back(e ? par : !par); total++; end
    end
    stop_ticks = !s ? OS : ((w == 2'b00) ? OS + OS / 2 : 2 * OS);
    repeat (stop_ticks) begin exp_lvl.push_back(1'b1); total++; end
    exp_len.push_back(total);
  endtask

  initial begin
    br = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (br_rand) begin
        br = ($urandom_range(0, 2) == 0) && !br;
      end else begin
        br = (br_cnt == 0);
        br_cnt = (br_cnt + 1 >= br_period) ? 0 : br_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      chk_end  = 1'b0;
      cur.delete();
    end else begin
      if (chk_end) begin
        chk_end = 1'b0;
        frames_done++;
        chk("end_ready", {tx, din_ready, busy}, 3'b110);
      end
      if (!in_frame && tx == 1'b0) begin
        chk("start_expected", int'(exp_len.size() > 0), 1);
        if (exp_len.size() > 0) begin
          len = exp_len.pop_front();
          cur.delete();
          for (int i = 0; i < len; i++) cur.push_back(exp_lvl.pop_front());
          in_frame  = 1'b1;
          idx       = 0;
          frame_bad = 1'b0;
        end
      end
      if (in_frame) begin
        if (tx != cur[idx] || !busy || din_ready) frame_bad = 1'b1;
        if (br) begin
          idx++;
          if (idx == len) begin
            in_frame = 1'b0;
            chk_end  = 1'b1;
            chk("frame", int'(frame_bad), 0);
          end
        end
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 one cycle after the accept edge.
  task automatic send(input logic [7:0] d, input logic [1:0] w,
                      input logic s, input logic p, input logic e);
    int n = 0;
    din = d; wls = w; stb = s; pen = p; eps = e; din_valid = 1'b1;
    @(negedge clk);
    while (!din_ready) begin
      n++;
      if (n > 20000) abort_run("accept_wait");
      @(negedge clk);
    end
    push_frame(d, w, s, p, e);
    @(posedge clk); #1;
    @(negedge clk);
    chk("start_latency", {tx, busy, din_ready}, 3'b010);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy || in_frame || chk_end || exp_len.size() != 0) begin
      n++;
      if (n > 20000) abort_run("idle_wait");
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    abort_run("watchdog");
  end

  initial begin
    int bad;
    int base;
    int n;
    rst = 1'b1; din_valid = 1'b0; din = '0; wls = '0; stb = 1'b0; pen = 1'b0; eps = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {tx, din_ready, busy}, 3'b110);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if ({tx, din_ready, busy} != 3'b110) bad++;
    end
    chk("idle_hold", bad, 0);
    @(posedge clk); #1;

    br_period = 6;
    send(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0);
    din_valid = 1'b0;
    wait_idle();

    br_period = 3;
    send(8'hFF, 2'b10, 1'b0, 1'b1, 1'b1);
    din_valid = 1'b0;
    wait_idle();
    send(8'hFF, 2'b10, 1'b0, 1'b1, 1'b0);
    din_valid = 1'b0;
    wait_idle();

    send(8'hE3, 2'b00, 1'b1, 1'b0, 1'b0);
    din_valid = 1'b0;
    wait_idle();

    base = frames_done;
    send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0);
    send(8'h0F, 2'b01, 1'b1, 1'b1, 1'b0);
    din_valid = 1'b0;
    wait_idle();
    chk("b2b_frames", frames_done - base, 2);

    br_period = 2;
    send(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0);
    din_valid = 1'b0;
    n = 0;
    while (n < 70) begin
      @(negedge clk);
      if (br) n++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_lvl.delete();
    exp_len.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midframe_reset", {tx, din_ready, busy}, 3'b110);
    @(posedge clk); #1;
    send(8'h5A, 2'b10, 1'b1, 1'b1, 1'b1);
    din_valid = 1'b0;
    wait_idle();

    for (int k = 0; k < 25; k++) begin
      br_period = $urandom_range(2, 5);
      br_rand   = ($urandom_range(0, 3) == 0);
      send(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        din_valid = 1'b0;
        din = 8'($urandom); wls = 2'($urandom); stb = 1'($urandom);
        pen = 1'($urandom); eps = 1'($urandom);
        wait_idle();
      end
    end
    din_valid = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit serializer of the UART SOC; sits directly downstream of baud_gen and consumes its `br` tick.
- Accepts one parallel character through a valid/ready handshake, then frames it: start bit, 5–8 data bits LSB first, optional parity, 1/1.5/2 stop bits.
- Drives the serial TX line.
- Every bit period is exactly 16 `br` pulses; `br` is a one-clk-wide pulse at 16x the baud rate.

Parameters:
- OVERSAMPLE, 16, number of `br` pulses per bit period; must be even (1.5 stop = 1.5*OVERSAMPLE).
- DATA_W, 8, maximum character width and width of `din`.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- br  input  1  baud tick from baud_gen; one-cycle pulse, 16x baud.
- din  input  DATA_W  character to send; bits above the configured word length are ignored.
- din_valid  input  1  `din` holds a character.
- din_ready  output  1  serializer can accept a character.
- wls  input  2  word length select: 00=5, 01=6, 10=7, 11=8 bits.
- stb  input  1  0=1 stop bit; 1=2 stop bits, or 1.5 stop bits when wls=00.
- pen  input  1  parity enable.
- eps  input  1  even parity select (1=even, 0=odd); meaningful only when pen=1.
- tx  output  1  serial line; idle and stop level is 1.
- busy  output  1  a frame is in progress (any state other than IDLE).

Behaviour:
- Reset values: tx=1, din_ready=1, busy=0, state=IDLE, tick counter=0, bit counter=0, shift register=0.
- Reset mid-frame aborts the frame immediately: tx returns to 1 on the next edge and the character is discarded.
- Handshake:
  - din_ready=1 only in IDLE; it is a registered state decode.
  - Transfer occurs on an edge where din_valid & din_ready.
  - On transfer, latch din, wls, stb, pen and eps into internal registers.
  - Configuration input changes during a frame have no effect on that frame.
- Latency: tx drives 0 (start bit) from the first cycle after the accept edge; din_ready and busy change on that same edge.
- Tick counting:
  - The tick counter clears on accept and increments only on cycles with br=1.
  - A bit ends on the br pulse that brings the count to OVERSAMPLE; the counter then wraps to 0 and the next bit's level appears on the following cycle.
  - br pulses seen in IDLE are ignored.
- States and transitions:
  - IDLE → START on accept.
  - START (tx=0, 16 ticks) → DATA.
  - DATA: tx = shift[0]; shift right at each bit end. The bit counter counts 0..wordlen-1. After the last data bit, go to PARITY if pen=1, else STOP.
  - PARITY (16 ticks):
    - even: tx = XOR of the wordlen data bits;
    - odd: tx = XNOR of the same bits.
    - Then → STOP.
  - STOP: tx=1; lasts 16 ticks (stb=0), 32 ticks (stb=1, wls≠00) or 24 ticks (stb=1, wls=00). Then → IDLE.
- Back-to-back characters: din_ready rises the cycle after the final stop tick. A character accepted on that cycle starts its start bit on the next cycle. No extra idle gap is inserted beyond these handshake cycles.
- Width rules:
  - Data bits not covered by wls are never shifted onto tx.
  - Parity covers only the transmitted data bits.
- busy = (state ≠ IDLE). tx is registered, never combinational from inputs.
- Simultaneous br and accept on the same edge: that br pulse is not counted toward the start bit.

Test Plan:
- Reset check: rst=1 for 2 cycles, then br pulsed every 4 clk with no valid → tx=1, din_ready=1, busy=0 throughout.
- 8N1 frame: wls=11, pen=0, stb=0, din=8'hA5, br every 6 clk → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 96 clk. din_ready returns 1 after 10 bit times.
- 7E1 parity: wls=10, pen=1, eps=1, din=8'hFF → 7 ones transmitted, parity bit=1, followed by 1 stop bit. Repeat with eps=0 → parity bit=0.
- 5-bit, 1.5 stop: wls=00, stb=1, din=8'hE3 → data 1,1,0,0,0 (bits 5–7 ignored); stop period = 24 br pulses.
- Back-to-back plus config change: hold din_valid with 8'h55 then 8'h0F, toggling wls mid-frame → first frame unaffected by the toggle; second start bit begins the cycle after the second accept; no extra gap; 2 accepts total.
- Reset mid-frame: assert rst during data bit 3 → next cycle tx=1, din_ready=1, busy=0. A new character then sends a clean full frame.
